// File: rtl/seq_serializer.sv
// Parallel-to-serial converter with valid/ready intake, per-cycle hold and
// back-to-back word chaining; drives a downstream sequence detector.
module seq_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             hold,
  output logic             seq,
  output logic             valid,
  output logic             word_done,
  output logic             busy
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_cnt;

  logic w_adv;
  logic w_last;
  logic w_head;
  logic w_accept;

  always_comb begin
    w_adv    = (r_state == SHIFT) && !hold;
    w_last   = w_adv && (r_cnt == LAST);
    w_head   = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];
    w_accept = in_valid && in_ready;
  end

  // Handshake and stream qualifiers are combinational so the last bit and the
  // next load share one edge without a bubble.
  assign valid     = w_adv;
  assign word_done = w_last;
  assign in_ready  = (r_state == IDLE) || w_last;
  assign busy      = (r_state == SHIFT);
  assign seq       = w_adv & w_head;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_state <= SHIFT;
      r_shreg <= in_data;
      r_cnt   <= '0;
    end else if (w_last) begin
      r_state <= IDLE;
    end else if (w_adv) begin
      r_cnt <= r_cnt + CW'(1);
      if (MSB_FIRST)
        r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
      else
        r_shreg <= {1'b0, r_shreg[WIDTH-1:1]};
    end
  end

endmodule

// File: tb/tb_seq_serializer.sv
// Checks an 8-bit MSB-first and a 4-bit LSB-first serializer against a
// bit-queue reference model under directed and random stimulus.
module tb_seq_serializer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       hold = 1'b0;

  logic [7:0] d8 = '0;
  logic       iv8 = 1'b0;
  logic       rdy8, seq8, val8, wd8, busy8;

  logic [3:0] d4 = '0;
  logic       iv4 = 1'b0;
  logic       rdy4, seq4, val4, wd4, busy4;

  always #5 clk = ~clk;

  seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u8 (
    .clk(clk), .reset(reset), .in_data(d8), .in_valid(iv8), .in_ready(rdy8),
    .hold(hold), .seq(seq8), .valid(val8), .word_done(wd8), .busy(busy8)
  );

  seq_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u4 (
    .clk(clk), .reset(reset), .in_data(d4), .in_valid(iv4), .in_ready(rdy4),
    .hold(hold), .seq(seq4), .valid(val4), .word_done(wd4), .busy(busy4)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Remaining bits of the word in flight, in transmission order.
  bit q8[$];
  bit q4[$];

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // {in_ready, busy, word_done, valid, seq}
  function automatic logic [4:0] expect_outs(input bit q[$], input bit h);
    bit b, v, s, wd;
    b  = (q.size() != 0);
    v  = b && !h;
    s  = v ? q[0] : 1'b0;
    wd = v && (q.size() == 1);
    return {(!b || wd), b, wd, v, s};
  endfunction

  task automatic check8(input logic [4:0] e);
    chk("in_ready8",  rdy8,  e[4]);
    chk("busy8",      busy8, e[3]);
    chk("word_done8", wd8,   e[2]);
    chk("valid8",     val8,  e[1]);
    chk("seq8",       seq8,  e[0]);
  endtask

  task automatic check4(input logic [4:0] e);
    chk("in_ready4",  rdy4,  e[4]);
    chk("busy4",      busy4, e[3]);
    chk("word_done4", wd4,   e[2]);
    chk("valid4",     val4,  e[1]);
    chk("seq4",       seq4,  e[0]);
  endtask

  task automatic step(input bit v8, input logic [7:0] dd8, input bit v4,
                      input logic [3:0] dd4, input bit h, input bit r);
    logic [4:0] e8, e4;
    @(negedge clk);
    iv8 = v8; d8 = dd8; iv4 = v4; d4 = dd4; hold = h; reset = r;
    if (r) begin
      q8.delete();
      q4.delete();
    end
    #1;
    e8 = expect_outs(q8, h);
    e4 = expect_outs(q4, h);
    check8(e8);
    check4(e4);
    @(posedge clk);
    if (!r) begin
      if (e8[1]) void'(q8.pop_front());
      if (v8 && e8[4]) for (int i = 7; i >= 0; i--) q8.push_back(dd8[i]);
      if (e4[1]) void'(q4.pop_front());
      if (v4 && e4[4]) for (int i = 0; i < 4; i++) q4.push_back(dd4[i]);
    end
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  // Reset raised between edges: outputs must fall without waiting for clk.
  task automatic async_reset;
    @(negedge clk);
    iv8 = 1'b0; iv4 = 1'b0; hold = 1'b0;
    #2;
    reset = 1'b1;
    q8.delete();
    q4.delete();
    #1;
    chk("async_busy8",  busy8, 1'b0);
    chk("async_valid8", val8,  1'b0);
    chk("async_seq8",   seq8,  1'b0);
    chk("async_wd8",    wd8,   1'b0);
    chk("async_rdy8",   rdy8,  1'b1);
    chk("async_busy4",  busy4, 1'b0);
    chk("async_valid4", val4,  1'b0);
    @(posedge clk);
  endtask

  initial begin
    // Reset held, with a word offered that must not be taken.
    step(1'b1, 8'hA5, 1'b1, 4'h9, 1'b0, 1'b1);
    step(1'b1, 8'hA5, 1'b1, 4'h9, 1'b1, 1'b1);
    idle_steps(2);

    // Single word 0xB6, hold in IDLE has no effect.
    step(1'b1, 8'hB6, 1'b0, 4'h0, 1'b0, 1'b0);
    idle_steps(8);
    step(1'b0, 8'h00, 1'b0, 4'h0, 1'b1, 1'b0);
    idle_steps(1);

    // Back-to-back 0xB6, 0x2D; 0x2D is offered early and ignored until ready.
    step(1'b1, 8'hB6, 1'b0, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 8'h2D, 1'b0, 4'h0, 1'b0, 1'b0);
    idle_steps(9);

    // Hold for three cycles after bit 3.
    step(1'b1, 8'hB6, 1'b0, 4'h0, 1'b0, 1'b0);
    idle_steps(4);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 4'h0, 1'b1, 1'b0);
    idle_steps(5);

    // Hold exactly on the last bit blocks both word_done and a pending load.
    step(1'b1, 8'h81, 1'b0, 4'h0, 1'b0, 1'b0);
    idle_steps(7);
    step(1'b1, 8'h5A, 1'b0, 4'h0, 1'b1, 1'b0);
    step(1'b1, 8'h5A, 1'b0, 4'h0, 1'b0, 1'b0);
    idle_steps(9);

    // Reset mid-word, then 0x01.
    step(1'b1, 8'hFF, 1'b1, 4'hF, 1'b0, 1'b0);
    idle_steps(4);
    async_reset();
    step(1'b0, 8'h00, 1'b0, 4'h0, 1'b0, 1'b1);
    step(1'b1, 8'h01, 1'b0, 4'h0, 1'b0, 1'b0);
    idle_steps(9);

    // LSB-first 4-bit word 0011, then a back-to-back pair.
    step(1'b0, 8'h00, 1'b1, 4'b0011, 1'b0, 1'b0);
    idle_steps(5);
    step(1'b0, 8'h00, 1'b1, 4'b1000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 4'b0110, 1'b0, 1'b0);
    idle_steps(5);

    // Random traffic with occasional hold and reset.
    for (int i = 0; i < 800; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
           4'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 63) == 0));
    end
    idle_steps(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_serializer.md
SEQ_SERIALIZER -- requirements
Module: seq_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the word width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 transmitted first, 0 = bit 0 first.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port in_data, input, WIDTH bits: parallel word to serialize.
REQ-006 The block SHALL have port in_valid, input, 1 bit: in_data valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: block can accept a word this cycle.
REQ-008 The block SHALL have port hold, input, 1 bit: 1 = freeze serial stream this cycle.
REQ-009 The block SHALL have port seq, output, 1 bit: current serial bit, feeding the downstream sequence detector seq input.
REQ-010 The block SHALL have port valid, output, 1 bit: seq valid this cycle, feeding the detector valid input.
REQ-011 The block SHALL have port word_done, output, 1 bit: one-cycle pulse on the last bit of a word.
REQ-012 The block SHALL have port busy, output, 1 bit: high while a word is being shifted.

Function
REQ-013 The block SHALL implement a two-state FSM: IDLE (no word held) and SHIFT (word in shift register).
REQ-014 The block SHALL hold a WIDTH-bit shift register and a bit counter cnt of width clog2(WIDTH), range 0..WIDTH-1.
REQ-015 A word SHALL be accepted on a rising edge where in_valid && in_ready; in_data loads the shift register, cnt <= 0, state <= SHIFT.
REQ-016 The block SHALL drive in_ready = (state==IDLE) || (state==SHIFT && cnt==WIDTH-1 && !hold), combinationally.
REQ-017 The block SHALL drive valid = (state==SHIFT) && !hold.
REQ-018 The block SHALL drive seq to the current head bit (MSB when MSB_FIRST=1, LSB otherwise) when valid=1, and to 0 when valid=0.
REQ-019 In SHIFT with hold=0 and cnt<WIDTH-1, each edge SHALL shift the register one position toward the head and increment cnt.
REQ-020 In SHIFT with hold=1, the register, cnt and state SHALL be unchanged; valid=0, word_done=0, in_ready=0.
REQ-021 The block SHALL drive word_done = (state==SHIFT) && cnt==WIDTH-1 && !hold, exactly one cycle per word.
REQ-022 On the last bit with in_valid=1, the new word SHALL load on that edge and SHIFT SHALL continue with no bubble; with in_valid=0 the state SHALL return to IDLE.
REQ-023 Latency SHALL be one cycle from the accept edge to the first valid bit; throughput SHALL be one word per WIDTH unheld cycles.
REQ-024 The block SHALL drive busy = (state==SHIFT), including held cycles.
REQ-025 In IDLE, hold SHALL have no effect, and in_data/in_valid SHALL be ignored unless in_ready=1.
REQ-026 Exactly WIDTH valid=1 cycles SHALL be produced per accepted word; no bit may be dropped or repeated.

Reset
REQ-027 While reset=1, state SHALL be IDLE, cnt 0 and shift register 0, immediately and independent of clk.
REQ-028 While reset=1, the outputs SHALL be: valid=0, seq=0, word_done=0, busy=0; in_ready SHALL be 1, but no word is accepted while reset is high.
REQ-029 Reset asserted mid-word SHALL discard the partial word; after release, the next accepted word starts at bit 0 of the new data.

Verification
REQ-030 Scenario, single word: WIDTH=8, MSB_FIRST=1, in_data=8'hB6 accepted at edge N -> cycles N+1..N+8 show valid=1 and seq=1,0,1,1,0,1,1,0; word_done=1 only at N+8; the detector reports detected once.
REQ-031 Scenario, back-to-back: 8'hB6 then 8'h2D with in_valid held high -> 16 contiguous valid cycles, seq=10110110 00101101, and in_ready high only at N and N+8.
REQ-032 Scenario, hold: hold=1 for 3 cycles after bit 3 of 8'hB6 -> valid=0 and seq=0 for those 3 cycles, busy stays 1, the stream resumes at bit 4, and word_done is delayed by 3 cycles.
REQ-033 Scenario, reset mid-word: reset pulsed after 4 bits of 8'hFF -> valid, busy and seq drop to 0 asynchronously; the next word 8'h01 produces seq=00000001.
REQ-034 Scenario, LSB first: MSB_FIRST=0, WIDTH=4, in_data=4'b0011 -> seq=1,1,0,0 and word_done on the 4th bit.
REQ-035 Scenario, no handshake: in_valid=1 while in_ready=0 mid-word -> that data is not loaded and the current word completes unchanged.
